// File: rtl/clk_profile_pkg.sv
// -----------------------------------------------------------------------------
// clk_profile_pkg
// Shared types and constants for the clock-profile sequencer and its table.
//   state_e          : sequencer FSM states (idle / running)
//   profile_t        : one table entry {period_hi, period_lo, jitter, dwell}
//   RST_PERIOD       : default period loaded into outputs and table at reset
//   PROFILE_DWELL_W  : storage width of the dwell field; the sequencer's
//                      DWELL_W parameter must not exceed it
//   profile_default  : builds the reset value of a table entry
// -----------------------------------------------------------------------------
package clk_profile_pkg;

    localparam logic [7:0] RST_PERIOD      = 8'd4;
    localparam int         PROFILE_DWELL_W = 32;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic [7:0]                 period_hi;
        logic [7:0]                 period_lo;
        logic [7:0]                 jitter;
        logic [PROFILE_DWELL_W-1:0] dwell;
    } profile_t;

    // Reset value of a table entry: default periods, no jitter, dwell of one edge.
    function automatic profile_t profile_default(input logic [7:0] rst_period);
        profile_t p;
        p.period_hi = rst_period;
        p.period_lo = rst_period;
        p.jitter    = 8'd0;
        p.dwell     = {{(PROFILE_DWELL_W-1){1'b0}}, 1'b1};
        return p;
    endfunction

endpackage

// File: rtl/clk_profile_table.sv
// -----------------------------------------------------------------------------
// clk_profile_table
// N_PROFILE-entry register file of clock profiles.
//   clk, rst  : clock and synchronous active-high reset (entries -> defaults)
//   wr_en     : write strobe; wr_data lands in entry wr_idx at the clock edge
//   rd_idx    : combinational read address
//   rd_data   : entry at rd_idx (registered contents, so writes show next cycle)
// -----------------------------------------------------------------------------
module clk_profile_table
    import clk_profile_pkg::*;
#(
    parameter int         N_PROFILE      = 4,
    parameter logic [7:0] DEFAULT_PERIOD = 8'd4,
    localparam int        IDX_W          = $clog2(N_PROFILE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  profile_t         wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output profile_t         rd_data
);

    profile_t mem_q [N_PROFILE];

    // Table storage: reset every entry to its default, otherwise accept one write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_PROFILE; i++) begin
                mem_q[i] <= profile_default(DEFAULT_PERIOD);
            end
        end else if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/clk_profile_sequencer.sv
// -----------------------------------------------------------------------------
// clk_profile_sequencer
// Steps a jittered clock generator through a table of profiles. Each profile
// is held for its programmed number of rising edges of the generated clock,
// after which the next entry is applied, the sequence wraps (loop) or ends.
//
// Ports
//   i_clk, i_rst              : root clock, synchronous active-high reset
//   i_wrEn/i_wrIdx/i_wr*      : table write port (accepted in any state)
//   i_lastIdx                 : final entry of the sequence (sampled each cycle)
//   i_loop                    : wrap to entry 0 after the final entry
//   i_start / i_stop          : begin at entry 0 / abort (stop wins)
//   i_genClk                  : generator output clock, sampled as data
//   o_periodHi/Lo, o_jitterControl : profile currently applied
//   o_profileIdx              : index of the applied entry
//   o_busy                    : sequence running
//   o_update                  : one-cycle pulse when a profile is applied
//   o_done                    : one-cycle pulse when a non-looping run ends
// All outputs are registered. DWELL_W must not exceed PROFILE_DWELL_W.
// -----------------------------------------------------------------------------
module clk_profile_sequencer #(
    parameter int         N_PROFILE  = 4,
    parameter int         DWELL_W    = 16,
    parameter logic [7:0] RST_PERIOD = 8'd4,
    localparam int        IDX_W      = $clog2(N_PROFILE)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_wrEn,
    input  logic [IDX_W-1:0]   i_wrIdx,
    input  logic [7:0]         i_wrPeriodHi,
    input  logic [7:0]         i_wrPeriodLo,
    input  logic [7:0]         i_wrJitter,
    input  logic [DWELL_W-1:0] i_wrDwell,
    input  logic [IDX_W-1:0]   i_lastIdx,
    input  logic               i_loop,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic               i_genClk,
    output logic [7:0]         o_periodHi,
    output logic [7:0]         o_periodLo,
    output logic [7:0]         o_jitterControl,
    output logic [IDX_W-1:0]   o_profileIdx,
    output logic               o_busy,
    output logic               o_update,
    output logic               o_done
);

    import clk_profile_pkg::*;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d, rd_idx;
    logic [DWELL_W-1:0] cnt_q, cnt_d, cnt_load;
    logic [7:0]         hi_q, hi_d, lo_q, lo_d, jit_q, jit_d;
    logic               busy_q, busy_d, update_q, update_d, done_q, done_d;
    logic               gen_prev_q, rise, at_last, apply;
    profile_t           wr_profile, rd_profile;

    assign wr_profile.period_hi = i_wrPeriodHi;
    assign wr_profile.period_lo = i_wrPeriodLo;
    assign wr_profile.jitter    = i_wrJitter;
    assign wr_profile.dwell     = PROFILE_DWELL_W'(i_wrDwell);

    clk_profile_table #(
        .N_PROFILE      (N_PROFILE),
        .DEFAULT_PERIOD (RST_PERIOD)
    ) u_table (
        .clk     (i_clk),
        .rst     (i_rst),
        .wr_en   (i_wrEn),
        .wr_idx  (i_wrIdx),
        .wr_data (wr_profile),
        .rd_idx  (rd_idx),
        .rd_data (rd_profile)
    );

    assign rise = i_genClk & ~gen_prev_q;

    // ">=" rather than "==" so that lowering i_lastIdx below the running index
    // ends the sequence at the next advance instead of running on to wrap.
    assign at_last = (idx_q >= i_lastIdx);

    // A stored dwell of zero behaves as one edge; the full-width compare keeps
    // the zero test exact regardless of the storage width.
    assign cnt_load = (rd_profile.dwell == {PROFILE_DWELL_W{1'b0}}) ?
                      DWELL_W'(1'b1) : rd_profile.dwell[DWELL_W-1:0];

    // Address of the entry the next application will use: idx+1 while running
    // short of the last entry, entry 0 for a fresh start or a loop wrap.
    always_comb begin
        rd_idx = {IDX_W{1'b0}};
        if ((state_q == ST_RUN) && !at_last) begin
            rd_idx = idx_q + IDX_W'(1'b1);
        end else begin
            rd_idx = {IDX_W{1'b0}};
        end
    end

    // FSM next state, dwell counting and next values of the output registers.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        jit_d    = jit_q;
        update_d = 1'b0;
        done_d   = 1'b0;
        apply    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_start && !i_stop) begin
                    apply   = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (i_stop) begin
                    state_d = ST_IDLE;
                end else if (rise) begin
                    if (cnt_q != DWELL_W'(1'b1)) begin
                        cnt_d = cnt_q - DWELL_W'(1'b1);
                    end else if (!at_last || i_loop) begin
                        apply = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (apply) begin
            idx_d    = rd_idx;
            cnt_d    = cnt_load;
            hi_d     = rd_profile.period_hi;
            lo_d     = rd_profile.period_lo;
            jit_d    = rd_profile.jitter;
            update_d = 1'b1;
        end else begin
            update_d = 1'b0;
        end

        busy_d = (state_d == ST_RUN);
    end

    // State, counter, edge-detect history and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= {IDX_W{1'b0}};
            cnt_q      <= DWELL_W'(1'b1);
            hi_q       <= RST_PERIOD;
            lo_q       <= RST_PERIOD;
            jit_q      <= 8'd0;
            busy_q     <= 1'b0;
            update_q   <= 1'b0;
            done_q     <= 1'b0;
            gen_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            jit_q      <= jit_d;
            busy_q     <= busy_d;
            update_q   <= update_d;
            done_q     <= done_d;
            gen_prev_q <= i_genClk;
        end
    end

    assign o_periodHi      = hi_q;
    assign o_periodLo      = lo_q;
    assign o_jitterControl = jit_q;
    assign o_profileIdx    = idx_q;
    assign o_busy          = busy_q;
    assign o_update        = update_q;
    assign o_done          = done_q;

endmodule

// File: doc/clk_profile_sequencer.md
# clk_profile_sequencer

Scheduler for the jittered clock generator. Holds a small table of clock profiles (high period, low period, jitter control, dwell). Steps the generator through the table, holding each profile for a programmed number of generated-clock rising edges, then stops or loops. Sits between the testbench or debug control path and the generator's `i_periodHi`/`i_periodLo`/`i_jitterControl` inputs. Watches the generator's output clock to count dwell.

## Interface
- `N_PROFILE`, 4: number of table entries; power of two, 2..16.
- `DWELL_W`, 16: dwell counter width.
- `RST_PERIOD`, 8'd4: reset value of both period outputs and every table period field.

Clock and reset are fixed: one clock, reset synchronous active-high.
- `i_clk`  in  1  root clock; same clock that drives the generator.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_wrEn`  in  1  table write strobe.
- `i_wrIdx`  in  $clog2(N_PROFILE)  entry to write.
- `i_wrPeriodHi`, `i_wrPeriodLo`, `i_wrJitter`  in  8 each  profile fields.
- `i_wrDwell`  in  DWELL_W  rising edges to hold the profile.
- `i_lastIdx`  in  $clog2(N_PROFILE)  final entry of the sequence.
- `i_loop`  in  1  after the last entry, wrap to entry 0.
- `i_start`  in  1  begin sequence at entry 0 (pulse).
- `i_stop`  in  1  abort sequence (pulse).
- `i_genClk`  in  1  generator output clock, sampled as data.
- `o_periodHi`, `o_periodLo`, `o_jitterControl`  out  8 each  to the generator.
- `o_profileIdx`  out  $clog2(N_PROFILE)  entry currently applied.
- `o_busy`  out  1  sequence running.
- `o_update`  out  1  one-cycle pulse; new profile applied this cycle.
- `o_done`  out  1  one-cycle pulse; sequence completed without loop.

## Operation
- **States:** IDLE and RUN.
- **Reset:**
  - State is IDLE.
  - Period outputs are `RST_PERIOD`; jitter is 0.
  - `o_profileIdx` is 0; `o_busy`, `o_update` and `o_done` are 0.
  - Every table entry is set to {`RST_PERIOD`, `RST_PERIOD`, 0, dwell 1}.
  - `genClk` history register is 0.
- **Table writes:**
  - Accepted in any state.
  - Table is registered; a write is visible from the next cycle.
  - Writing the currently applied entry does not change the outputs until that entry is next applied.
- **IDLE → RUN** on `i_start && !i_stop`:
  - Apply entry 0 and load dwell counter with max(dwell, 1).
  - Assert `o_update` and `o_busy`.
- **Rising-edge detect:** `rise = i_genClk && !genClkPrev_q`.
- **RUN, each rise:**
  - If counter != 1: decrement the counter.
  - Else, if idx != `i_lastIdx`: apply idx+1.
  - Else, if `i_loop`: apply entry 0.
  - Else: go to IDLE and pulse `o_done`.
- **Every application** pulses `o_update`, updates `o_profileIdx`, and reloads the counter.
- **Stop:** `i_stop` in RUN forces IDLE next cycle, without `o_done`. Outputs hold the last applied profile.
- **Start while busy:** `i_start` in RUN is ignored.
- **Start and stop together:** stop wins.
- **Last index:** `i_lastIdx` is sampled every cycle. If it is below the current idx, the sequence ends at the next advance (loop or done as above).
- **Arithmetic:** index increments modulo `N_PROFILE`. Dwell 0 is treated as 1.

## Timing
- **Start to outputs:** `i_start` at cycle t → outputs valid, `o_update`=1 and `o_busy`=1 at t+1.
- **Final rise to next profile:** `i_genClk` rises at cycle t (sampled 1 with previous 0) on the final dwell edge → new profile and `o_update` at t+1.
- **Completion:** `o_done` is asserted in the same cycle `o_busy` falls.
- **Other latencies:** stop and reset each take effect in one cycle.
- **No combinational paths:** every output is registered; nothing is combinational from input to output.

## Structure
- **Shared package `clk_profile_pkg`:**
  - State enum {IDLE, RUN}.
  - Profile struct typedef {periodHi, periodLo, jitter, dwell}.
  - `RST_PERIOD` constant.
- **Sub-module `clk_profile_table`:**
  - `N_PROFILE`-entry register file with synchronous reset to defaults.
  - One write port and one combinational read port indexed by next idx.
- The top level holds the FSM, edge detector, dwell counter and output registers.

## Test plan
1. **Single pass:**
   - Stimulus: entries 0/1 = {2,2,0,dwell 3} and {5,1,0,dwell 2}; `lastIdx`=1, `loop`=0; start.
   - Response: period outputs 2/2 for exactly 3 genClk rises, then 5/1 for 2 rises. `o_done` 1 cycle after the 5th rise; `o_busy` falls the same cycle; outputs hold 5/1.
2. **Loop:**
   - Stimulus: same table with `loop`=1.
   - Response: `o_profileIdx` sequence 0,1,0,1 with `o_update` at each change; `o_done` never asserted.
3. **Stop mid-run:**
   - Stimulus: `i_stop` on the 2nd rise of entry 0.
   - Response: IDLE next cycle, no `o_done`, outputs stay 2/2. A following `i_start` restarts at entry 0 with the full dwell.
4. **Dwell 0 and start+stop:**
   - Stimulus: entry 0 dwell=0; assert start and stop together, then start alone.
   - Response: the combined pulse is ignored. After start alone, the entry is held 1 rise.
5. **Write during run:**
   - Stimulus: rewrite entry 0 to {9,9,3} while it is applied.
   - Response: outputs unchanged until the loop reapplies entry 0, then 9/9/3.
6. **Reset mid-run:**
   - Stimulus: `i_rst` during entry 1.
   - Response: next cycle outputs 4/4/0, idx 0, `o_busy`=0, and the table reads back defaults.
